// File: rtl/axils_regfile.sv
// axils_regfile: AXI4-Lite slave register file with byte-strobe writes, SLVERR decode and flat register output.
module axils_regfile #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [31:0]            AWADDR,
  input  logic [2:0]             AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [1:0]             BRESP,
  input  logic [31:0]            ARADDR,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [NUM_REGS*32-1:0] REG_OUT
);
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] regs [NUM_REGS];
  logic [31:0] aw_addr, w_data, wr_addr, wr_data, wr_idx, rd_idx, rd_val;
  logic [3:0] w_strb, wr_strb;
  logic aw_hs, w_hs, ar_hs, wr_en;
  logic unused;
  assign unused = ^{AWPROT, ARPROT};
  assign AWREADY = (w_state == W_IDLE) || (w_state == W_HAVE_D);
  assign WREADY = (w_state == W_IDLE) || (w_state == W_HAVE_A);
  assign BVALID = w_state == W_RESP;
  assign ARREADY = r_state == R_IDLE;
  assign RVALID = r_state == R_RESP;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  // whichever half arrives on the completing edge comes from the bus, the other from its latch
  assign wr_addr = aw_hs ? AWADDR : aw_addr;
  assign wr_data = w_hs ? WDATA : w_data;
  assign wr_strb = w_hs ? WSTRB : w_strb;
  assign wr_idx = (wr_addr - BASE_ADDR) >> 2;
  assign rd_idx = (ARADDR - BASE_ADDR) >> 2;
  always_comb begin
    w_next = w_state;
    wr_en = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next = W_RESP;
          wr_en = 1'b1;
        end else if (aw_hs) w_next = W_HAVE_A;
        else if (w_hs) w_next = W_HAVE_D;
      end
      W_HAVE_A: begin
        w_next = w_hs ? W_RESP : W_HAVE_A;
        wr_en = w_hs;
      end
      W_HAVE_D: begin
        w_next = aw_hs ? W_RESP : W_HAVE_D;
        wr_en = aw_hs;
      end
      default: w_next = BREADY ? W_IDLE : W_RESP;
    endcase
  end
  always_comb r_next = (r_state == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (RREADY ? R_IDLE : R_RESP);
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) if (rd_idx == 32'(i)) rd_val = regs[i];
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      BRESP <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_addr <= AWADDR;
      if (w_hs) w_data <= WDATA;
      if (w_hs) w_strb <= WSTRB;
      if (wr_en) BRESP <= (wr_idx < 32'(NUM_REGS)) ? 2'b00 : 2'b10;
      if (wr_en)
        for (int i = 0; i < NUM_REGS; i++)
          for (int b = 0; b < 4; b++)
            if (wr_idx == 32'(i) && wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      RDATA <= '0;
      RRESP <= 2'b00;
    end else begin
      r_state <= r_next;
      if (ar_hs) RDATA <= rd_val;
      if (ar_hs) RRESP <= (rd_idx < 32'(NUM_REGS)) ? 2'b00 : 2'b10;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) assign REG_OUT[32*g +: 32] = regs[g];
endmodule

// File: doc/axils_regfile.md
Name: axils_regfile

Overview:
- AXI4-Lite slave register file that sits directly downstream of the AXI4-Lite master bridge and terminates its five channels.
- Holds NUM_REGS 32-bit registers with byte-strobe writes and per-transaction OKAY/SLVERR responses.
- Drives all register contents out on a flat bus for consumption by local hardware.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (1..256).
- BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned.

Ports:
- ACLK  input  1  clock; all logic is rising-edge.
- ARESET  input  1  asynchronous, active-high reset.
- AWADDR  input  32  write address.
- AWPROT  input  3  ignored.
- AWVALID  input  1  write address valid.
- AWREADY  output  1  write address ready.
- WDATA  input  32  write data.
- WSTRB  input  4  byte strobes; bit i enables WDATA[8i+7:8i].
- WVALID  input  1  write data valid.
- WREADY  output  1  write data ready.
- BVALID  output  1  write response valid.
- BREADY  input  1  write response ready.
- BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- ARADDR  input  32  read address.
- ARPROT  input  3  ignored.
- ARVALID  input  1  read address valid.
- ARREADY  output  1  read address ready.
- RDATA  output  32  read data.
- RRESP  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- RVALID  output  1  read data valid.
- RREADY  input  1  read data ready.
- REG_OUT  output  NUM_REGS*32  register i appears on bits [32i+31:32i].

Behaviour:
- Reset: ARESET asserts asynchronously and forces the following values:
  - all registers = 0, so REG_OUT = 0;
  - AWREADY = WREADY = ARREADY = 1;
  - BVALID = RVALID = 0, BRESP = RRESP = 2'b00, RDATA = 0;
  - both FSMs to IDLE.
- Reset mid-transaction abandons the transaction; no response is issued afterwards.
- Decode: offset = ADDR - BASE_ADDR (32-bit modulo), ADDR[1:0] ignored, index = offset >> 2.
  - In range: index < NUM_REGS.
  - Out of range: SLVERR.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: AWREADY = WREADY = 1.
    - AW and W handshake in the same cycle: write on that edge, go to W_RESP.
    - AW only: latch address, go to W_HAVE_A.
    - W only: latch data and strobes, go to W_HAVE_D.
  - W_HAVE_A: AWREADY = 0, WREADY = 1. On W handshake: write using the latched address, go to W_RESP.
  - W_HAVE_D: AWREADY = 1, WREADY = 0. On AW handshake: write using the latched data, go to W_RESP.
  - W_RESP: AWREADY = WREADY = 0, BVALID = 1, BRESP held stable. On BREADY: go to W_IDLE.
- Write timing: BVALID rises the cycle after the later of the AW and W handshakes; back-to-back writes cost 1 cycle per response when BREADY = 1.
- Write effect: only bytes with WSTRB set change; WSTRB = 4'b0000 changes nothing and returns OKAY.
- Out-of-range write: no register changes, BRESP = SLVERR.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY = 1. On AR handshake: capture RDATA and RRESP, go to R_RESP.
  - R_RESP: ARREADY = 0, RVALID = 1, RDATA and RRESP held stable. On RREADY: go to R_IDLE, RVALID = 0 next cycle.
- Read timing: RVALID is high the cycle after the AR handshake.
- Out-of-range read: RDATA = 0, RRESP = SLVERR.
- Concurrency: one outstanding write and one outstanding read, fully independent.
  - A read captured on the same edge as a write to the same register returns the pre-write value.
- REG_OUT reflects a write on the cycle after the write edge; it is registered, not combinational from the bus.
- VALID without READY: inputs are not sampled. The slave never drops an asserted BVALID or RVALID before the matching READY.

Test Plan:
- Reset, then write 0x0000_0008 with WDATA = 0xDEADBEEF, WSTRB = 4'hF, AW and W in the same cycle -> BVALID on the next cycle with BRESP = 00; then read 0x08 -> RDATA = 0xDEADBEEF, RRESP = 00; REG_OUT[95:64] = 0xDEADBEEF.
- Present W 3 cycles before AW (and a second case with AW 3 cycles before W) -> one write only; BVALID one cycle after the later handshake; WREADY = 0 (respectively AWREADY = 0) while waiting.
- Register 1 = 0x1122_3344, then write 0xAABB_CCDD with WSTRB = 4'b0101 -> register 1 = 0x11BB_33DD.
- Write and read to address 0x40 (index 16) with NUM_REGS = 16 -> BRESP = 10, RRESP = 10, RDATA = 0, no register changed.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stable; AWREADY, WREADY and ARREADY = 0 throughout.
- Assert ARESET while in W_HAVE_A -> immediately AWREADY = WREADY = 1, BVALID = 0, REG_OUT = 0; a W after reset is treated as a new transaction (W_HAVE_D).
